// File: rtl/n64a_vinfo_det_pkg.sv
// rtl/n64a_vinfo_det_pkg.sv - shared constants and types for the N64 video-info extractor
package n64a_vinfo_det_pkg;

    localparam int SYNC_VSYNC = 3;
    localparam int SYNC_CLAMP = 2;
    localparam int SYNC_HSYNC = 1;
    localparam int SYNC_CSYNC = 0;

    localparam int VINFO_DCNT_HI = 3;
    localparam int VINFO_DCNT_LO = 2;
    localparam int VINFO_VMODE   = 1;
    localparam int VINFO_480I    = 0;

    localparam int LINE_CNT_W_DEF = 10;
    localparam int PAL_THRESH_DEF = 288;
    localparam int MAX_VALID_DEF  = 400;
    localparam int DEBOUNCE_DEF   = 2;

    // Field order matches the VINFO_* slice indices above.
    typedef struct packed {
        logic [1:0] dcnt;
        logic       vmode;
        logic       n64_480i;
    } vinfo_t;

    function automatic logic edge_fall(input logic strobe, input logic prev, input logic cur);
        return strobe & prev & ~cur;
    endfunction

endpackage

// File: rtl/n64a_vinfo_det_if.sv
// rtl/n64a_vinfo_det_if.sv - VI sync input and video-info output bundle
interface n64a_vinfo_det_if
    import n64a_vinfo_det_pkg::*;
#(
    parameter int LINE_CNT_W = LINE_CNT_W_DEF
);
    logic                  nVDSYNC;
    logic [3:0]            Sync_pre;
    logic [3:0]            Sync_cur;
    logic [3:0]            vinfo_o;
    logic                  field_o;
    logic [LINE_CNT_W-1:0] vlines_o;

    modport master (
        output nVDSYNC, Sync_pre, Sync_cur,
        input  vinfo_o, field_o, vlines_o
    );

    modport slave (
        input  nVDSYNC, Sync_pre, Sync_cur,
        output vinfo_o, field_o, vlines_o
    );
endinterface

// File: rtl/vinfo_debounce.sv
// rtl/vinfo_debounce.sv - flag that flips only after DEBOUNCE consecutive disagreeing votes
module vinfo_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vote_strobe_i,
    input  logic vote_i,
    output logic flag_o
);
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE - 1);

    logic          flag_q, flag_d;
    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        flag_d   = flag_q;
        streak_d = streak_q;
        if (vote_strobe_i) begin
            if (vote_i == flag_q) begin
                streak_d = '0;
            end else if (streak_q == LAST) begin
                flag_d   = ~flag_q;
                streak_d = '0;
            end else begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            flag_q   <= flag_d;
            streak_q <= streak_d;
        end
    end

    assign flag_o = flag_q;
endmodule

// File: rtl/n64a_vinfo_det.sv
// rtl/n64a_vinfo_det.sv - extracts data phase, PAL/NTSC, 480i, field and line count from the VI sync nibble
module n64a_vinfo_det
    import n64a_vinfo_det_pkg::*;
#(
    parameter int LINE_CNT_W = LINE_CNT_W_DEF,
    parameter int PAL_THRESH = PAL_THRESH_DEF,
    parameter int MAX_VALID  = MAX_VALID_DEF,
    parameter int DEBOUNCE   = DEBOUNCE_DEF
) (
    input  logic VCLK,
    input  logic VRST,
    n64a_vinfo_det_if.slave bus
);
    localparam logic [LINE_CNT_W-1:0] PAL_C = LINE_CNT_W'(PAL_THRESH);
    localparam logic [LINE_CNT_W-1:0] MAX_C = LINE_CNT_W'(MAX_VALID);
    localparam logic [LINE_CNT_W-1:0] SAT_C = '1;

    logic                  strobe, hs_fall, vs_fall, field_new;
    logic                  vote_valid, pal_vote, ilace_vote;
    logic                  vmode, n64_480i;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_CNT_W-1:0] vlines_q, vlines_d;
    logic                  field_q, field_d;
    vinfo_t                vinfo;
    logic                  unused_sync;

    assign strobe    = ~bus.nVDSYNC;
    assign hs_fall   = edge_fall(strobe, bus.Sync_pre[SYNC_HSYNC], bus.Sync_cur[SYNC_HSYNC]);
    assign vs_fall   = edge_fall(strobe, bus.Sync_pre[SYNC_VSYNC], bus.Sync_cur[SYNC_VSYNC]);
    assign field_new = bus.Sync_cur[SYNC_HSYNC];

    // Overlong fields (including a saturated counter) are treated as garbage and never vote.
    assign vote_valid = vs_fall & (line_cnt_q < MAX_C);
    assign pal_vote   = (line_cnt_q >= PAL_C);
    assign ilace_vote = field_new ^ field_q;

    always_comb begin
        dcnt_d     = strobe ? 2'd1 : dcnt_q + 2'd1;
        line_cnt_d = line_cnt_q;
        vlines_d   = vlines_q;
        field_d    = field_q;
        // vsync takes priority: a coincident hsync edge belongs to the new field and is not counted.
        if (vs_fall) begin
            vlines_d   = line_cnt_q;
            line_cnt_d = '0;
            field_d    = field_new;
        end else if (hs_fall && (line_cnt_q != SAT_C)) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end
    end

    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            dcnt_q     <= 2'd0;
            line_cnt_q <= '0;
            vlines_q   <= '0;
            field_q    <= 1'b0;
        end else begin
            dcnt_q     <= dcnt_d;
            line_cnt_q <= line_cnt_d;
            vlines_q   <= vlines_d;
            field_q    <= field_d;
        end
    end

    vinfo_debounce #(.DEBOUNCE(DEBOUNCE)) u_vmode_db (
        .clk           (VCLK),
        .rst           (VRST),
        .vote_strobe_i (vote_valid),
        .vote_i        (pal_vote),
        .flag_o        (vmode)
    );

    vinfo_debounce #(.DEBOUNCE(DEBOUNCE)) u_480i_db (
        .clk           (VCLK),
        .rst           (VRST),
        .vote_strobe_i (vote_valid),
        .vote_i        (ilace_vote),
        .flag_o        (n64_480i)
    );

    assign vinfo.dcnt     = dcnt_q;
    assign vinfo.vmode    = vmode;
    assign vinfo.n64_480i = n64_480i;

    assign bus.vinfo_o  = vinfo;
    assign bus.field_o  = field_q;
    assign bus.vlines_o = vlines_q;

    assign unused_sync = ^{bus.Sync_pre[SYNC_CLAMP], bus.Sync_pre[SYNC_CSYNC],
                           bus.Sync_cur[SYNC_CLAMP], bus.Sync_cur[SYNC_CSYNC]};
endmodule
